// File: rtl/mmio_host_arbiter.sv
// Two-requester MMIO host port arbiter: independent read and write channels,
// each with round-robin grant locked until downstream ack, plus a hung-access timeout.

module mmio_arb_channel #(
   parameter int PW             = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          req_a_i,
   input  logic          req_b_i,
   input  logic [PW-1:0] pay_a_i,
   input  logic [PW-1:0] pay_b_i,
   input  logic          dev_ack_i,
   output logic          dev_req_o,
   output logic [PW-1:0] dev_pay_o,
   output logic          ack_a_o,
   output logic          ack_b_o,
   output logic          tmo_o
);

   // state | meaning
   // IDLE  | no transaction; downstream driven 0, dev ack ignored
   // BUSY  | owner_q holds the grant until ack, drop or timeout
   typedef enum logic {IDLE, BUSY} state_t;

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

   state_t        state_q, state_d;
   logic          owner_q, owner_d;   // 0 = A, 1 = B
   logic          prio_q, prio_d;     // side that wins a tie
   logic [CW-1:0] cnt_q, cnt_d;
   logic          own_req;
   logic [PW-1:0] own_pay;
   logic          complete;

   assign own_req = owner_q ? req_b_i : req_a_i;
   assign own_pay = owner_q ? pay_b_i : pay_a_i;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         prio_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         prio_q  <= prio_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      prio_d    = prio_q;
      cnt_d     = cnt_q;
      dev_req_o = 1'b0;
      dev_pay_o = '0;
      ack_a_o   = 1'b0;
      ack_b_o   = 1'b0;
      tmo_o     = 1'b0;
      complete  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (req_a_i || req_b_i) begin
               owner_d = (req_a_i && req_b_i) ? prio_q : req_b_i;
               state_d = BUSY;
               cnt_d   = '0;
            end
         end
         BUSY: begin
            if (!own_req) begin
               state_d = IDLE;
            end else if (dev_ack_i) begin
               dev_req_o = 1'b1;
               dev_pay_o = own_pay;
               complete  = 1'b1;
            end else if (TMO_EN && (cnt_q == CNT_LAST)) begin
               tmo_o    = 1'b1;
               complete = 1'b1;
            end else begin
               dev_req_o = 1'b1;
               dev_pay_o = own_pay;
               cnt_d     = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (complete) begin
         ack_a_o = ~owner_q;
         ack_b_o = owner_q;
         prio_d  = ~owner_q;
         state_d = IDLE;
      end

      // A reset cycle aborts whatever is in flight without any completion.
      if (reset) begin
         dev_req_o = 1'b0;
         dev_pay_o = '0;
         ack_a_o   = 1'b0;
         ack_b_o   = 1'b0;
         tmo_o     = 1'b0;
      end
   end

endmodule

module mmio_host_arbiter #(
   parameter int                    INDEX_WIDTH       = 32,
   parameter int                    DATA_WIDTH        = 32,
   parameter int                    TIMEOUT_CYCLES    = 1024,
   parameter logic [DATA_WIDTH-1:0] TIMEOUT_READ_DATA = 32'hDEADBEEF
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   a_read_req,
   input  logic                   b_read_req,
   input  logic [INDEX_WIDTH-1:0] a_read_index,
   input  logic [INDEX_WIDTH-1:0] b_read_index,
   output logic                   a_read_ack,
   output logic                   b_read_ack,
   output logic [DATA_WIDTH-1:0]  a_read_data,
   output logic [DATA_WIDTH-1:0]  b_read_data,
   input  logic                   a_write_req,
   input  logic                   b_write_req,
   input  logic [INDEX_WIDTH-1:0] a_write_index,
   input  logic [INDEX_WIDTH-1:0] b_write_index,
   input  logic [DATA_WIDTH-1:0]  a_write_data,
   input  logic [DATA_WIDTH-1:0]  b_write_data,
   output logic                   a_write_ack,
   output logic                   b_write_ack,
   output logic                   dev_read_req,
   output logic [INDEX_WIDTH-1:0] dev_read_index,
   input  logic                   dev_read_ack,
   input  logic [DATA_WIDTH-1:0]  dev_read_data,
   output logic                   dev_write_req,
   output logic [INDEX_WIDTH-1:0] dev_write_index,
   output logic [DATA_WIDTH-1:0]  dev_write_data,
   input  logic                   dev_write_ack,
   output logic                   read_timeout,
   output logic                   write_timeout,
   input  logic                   timeout_clear
);

   localparam int WPW = INDEX_WIDTH + DATA_WIDTH;

   logic                  rd_tmo, wr_tmo;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [WPW-1:0]        wr_pay;
   logic                  read_timeout_q, write_timeout_q;

   mmio_arb_channel #(.PW(INDEX_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rd (
      .clock     (clock),
      .reset     (reset),
      .req_a_i   (a_read_req),
      .req_b_i   (b_read_req),
      .pay_a_i   (a_read_index),
      .pay_b_i   (b_read_index),
      .dev_ack_i (dev_read_ack),
      .dev_req_o (dev_read_req),
      .dev_pay_o (dev_read_index),
      .ack_a_o   (a_read_ack),
      .ack_b_o   (b_read_ack),
      .tmo_o     (rd_tmo)
   );

   mmio_arb_channel #(.PW(WPW), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wr (
      .clock     (clock),
      .reset     (reset),
      .req_a_i   (a_write_req),
      .req_b_i   (b_write_req),
      .pay_a_i   ({a_write_index, a_write_data}),
      .pay_b_i   ({b_write_index, b_write_data}),
      .dev_ack_i (dev_write_ack),
      .dev_req_o (dev_write_req),
      .dev_pay_o (wr_pay),
      .ack_a_o   (a_write_ack),
      .ack_b_o   (b_write_ack),
      .tmo_o     (wr_tmo)
   );

   assign {dev_write_index, dev_write_data} = wr_pay;

   assign rd_data     = rd_tmo ? TIMEOUT_READ_DATA : dev_read_data;
   assign a_read_data = a_read_ack ? rd_data : '0;
   assign b_read_data = b_read_ack ? rd_data : '0;

   // A timeout in the same cycle as a clear wins: the flag still sets.
   always_ff @(posedge clock) begin
      if (reset) begin
         read_timeout_q  <= 1'b0;
         write_timeout_q <= 1'b0;
      end else begin
         read_timeout_q  <= rd_tmo | (read_timeout_q & ~timeout_clear);
         write_timeout_q <= wr_tmo | (write_timeout_q & ~timeout_clear);
      end
   end

   assign read_timeout  = read_timeout_q;
   assign write_timeout = write_timeout_q;

endmodule

// File: tb/tb_mmio_host_arbiter.sv
// Bench for mmio_host_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a transaction-level model.

module tb_mmio_host_arbiter;

   localparam int          TMO      = 8;
   localparam logic [31:0] TMO_DATA = 32'hDEADBEEF;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset, timeout_clear;
   logic        dev_read_ack, dev_write_ack;
   logic [31:0] dev_read_data;

   // requester stimulus: [channel 0=read 1=write][side 0=A 1=B]
   logic        r_req [2][2];
   logic [31:0] r_idx [2][2];
   logic [31:0] r_dat [2][2];

   logic        a_read_ack, b_read_ack, a_write_ack, b_write_ack;
   logic [31:0] a_read_data, b_read_data;
   logic        dev_read_req, dev_write_req;
   logic [31:0] dev_read_index, dev_write_index, dev_write_data;
   logic        read_timeout, write_timeout;

   mmio_host_arbiter #(
      .INDEX_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO), .TIMEOUT_READ_DATA(TMO_DATA)
   ) dut (
      .clock(clock), .reset(reset),
      .a_read_req(r_req[0][0]), .b_read_req(r_req[0][1]),
      .a_read_index(r_idx[0][0]), .b_read_index(r_idx[0][1]),
      .a_read_ack(a_read_ack), .b_read_ack(b_read_ack),
      .a_read_data(a_read_data), .b_read_data(b_read_data),
      .a_write_req(r_req[1][0]), .b_write_req(r_req[1][1]),
      .a_write_index(r_idx[1][0]), .b_write_index(r_idx[1][1]),
      .a_write_data(r_dat[1][0]), .b_write_data(r_dat[1][1]),
      .a_write_ack(a_write_ack), .b_write_ack(b_write_ack),
      .dev_read_req(dev_read_req), .dev_read_index(dev_read_index),
      .dev_read_ack(dev_read_ack), .dev_read_data(dev_read_data),
      .dev_write_req(dev_write_req), .dev_write_index(dev_write_index),
      .dev_write_data(dev_write_data), .dev_write_ack(dev_write_ack),
      .read_timeout(read_timeout), .write_timeout(write_timeout),
      .timeout_clear(timeout_clear)
   );

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;

   // model: owner of the transaction in flight (-1 none), its age, tie winner, flags
   int m_owner [2], m_age [2], m_ptr [2], m_flag [2];
   int n_owner [2], n_age [2], n_ptr [2], n_flag [2];
   logic e_ack [2][2];

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_n, act, exp);
      end
   endtask

   task automatic cmp1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %b expected %b", name, cyc_n, act, exp);
      end
   endtask

   task automatic eval_cycle();
      logic        dack [2];
      logic        e_req [2];
      logic [31:0] e_idx [2], e_dat [2];
      logic [31:0] e_rd [2];
      logic        set [2];
      int          o;
      @(negedge clock);
      dack[0] = dev_read_ack;
      dack[1] = dev_write_ack;
      e_rd[0] = '0;
      e_rd[1] = '0;
      for (int ch = 0; ch < 2; ch++) begin
         e_req[ch] = 1'b0; e_idx[ch] = '0; e_dat[ch] = '0; set[ch] = 1'b0;
         e_ack[ch][0] = 1'b0; e_ack[ch][1] = 1'b0;
         n_owner[ch] = m_owner[ch]; n_age[ch] = m_age[ch]; n_ptr[ch] = m_ptr[ch];
         if (reset) begin
            n_owner[ch] = -1; n_age[ch] = 0; n_ptr[ch] = 0;
         end else if (m_owner[ch] < 0) begin
            if (r_req[ch][0] || r_req[ch][1]) begin
               n_owner[ch] = (r_req[ch][0] && r_req[ch][1]) ? m_ptr[ch] : (r_req[ch][0] ? 0 : 1);
               n_age[ch]   = 0;
            end
         end else begin
            o = m_owner[ch];
            if (!r_req[ch][o]) begin
               n_owner[ch] = -1;
            end else if (dack[ch] || (TMO > 0 && m_age[ch] == TMO - 1)) begin
               e_ack[ch][o] = 1'b1;
               n_owner[ch]  = -1;
               n_ptr[ch]    = 1 - o;
               if (dack[ch]) begin
                  e_req[ch] = 1'b1; e_idx[ch] = r_idx[ch][o]; e_dat[ch] = r_dat[ch][o];
                  if (ch == 0) e_rd[o] = dev_read_data;
               end else begin
                  set[ch] = 1'b1;
                  if (ch == 0) e_rd[o] = TMO_DATA;
               end
            end else begin
               e_req[ch] = 1'b1; e_idx[ch] = r_idx[ch][o]; e_dat[ch] = r_dat[ch][o];
               n_age[ch] = m_age[ch] + 1;
            end
         end
         if (reset)              n_flag[ch] = 0;
         else if (set[ch])       n_flag[ch] = 1;
         else if (timeout_clear) n_flag[ch] = 0;
         else                    n_flag[ch] = m_flag[ch];
      end
      cmp1("dev_read_req", dev_read_req, e_req[0]);
      cmp ("dev_read_index", dev_read_index, e_idx[0]);
      cmp1("dev_write_req", dev_write_req, e_req[1]);
      cmp ("dev_write_index", dev_write_index, e_idx[1]);
      cmp ("dev_write_data", dev_write_data, e_dat[1]);
      cmp1("a_read_ack", a_read_ack, e_ack[0][0]);
      cmp1("b_read_ack", b_read_ack, e_ack[0][1]);
      cmp ("a_read_data", a_read_data, e_rd[0]);
      cmp ("b_read_data", b_read_data, e_rd[1]);
      cmp1("a_write_ack", a_write_ack, e_ack[1][0]);
      cmp1("b_write_ack", b_write_ack, e_ack[1][1]);
      cmp1("read_timeout", read_timeout, m_flag[0] != 0);
      cmp1("write_timeout", write_timeout, m_flag[1] != 0);
   endtask

   task automatic advance();
      @(posedge clock);
      #1;
      cyc_n++;
      for (int ch = 0; ch < 2; ch++) begin
         m_owner[ch] = n_owner[ch]; m_age[ch] = n_age[ch];
         m_ptr[ch]   = n_ptr[ch];   m_flag[ch] = n_flag[ch];
      end
   endtask

   task automatic quiet();
      for (int ch = 0; ch < 2; ch++)
         for (int s = 0; s < 2; s++) begin
            r_req[ch][s] = 1'b0; r_idx[ch][s] = '0; r_dat[ch][s] = '0;
         end
      dev_read_ack = 1'b0; dev_write_ack = 1'b0; dev_read_data = '0;
      timeout_clear = 1'b0;
   endtask

   task automatic drive_random(input int ackpct);
      for (int ch = 0; ch < 2; ch++)
         for (int s = 0; s < 2; s++) begin
            if (r_req[ch][s] && e_ack[ch][s]) begin
               r_req[ch][s] = ($urandom_range(0, 1) == 1);
               r_idx[ch][s] = $urandom; r_dat[ch][s] = $urandom;
            end else if (r_req[ch][s]) begin
               if ($urandom_range(0, 99) == 0) r_req[ch][s] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               r_req[ch][s] = 1'b1;
               r_idx[ch][s] = $urandom; r_dat[ch][s] = $urandom;
            end
         end
      dev_read_ack  = ($urandom_range(0, 99) < ackpct);
      dev_write_ack = ($urandom_range(0, 99) < ackpct);
      dev_read_data = $urandom;
      timeout_clear = ($urandom_range(0, 19) == 0);
      reset         = ($urandom_range(0, 399) == 0);
   endtask

   initial begin
      for (int ch = 0; ch < 2; ch++) begin
         m_owner[ch] = -1; m_age[ch] = 0; m_ptr[ch] = 0; m_flag[ch] = 0;
         n_owner[ch] = -1; n_age[ch] = 0; n_ptr[ch] = 0; n_flag[ch] = 0;
         e_ack[ch][0] = 1'b0; e_ack[ch][1] = 1'b0;
      end
      quiet();
      reset = 1'b1;
      advance();
      eval_cycle();
      cmp1("rst_rd_to", read_timeout, 1'b0);
      cmp1("rst_dev_rd", dev_read_req, 1'b0);
      advance();
      reset = 1'b0;

      // single read, device acks three cycles after dev req rises
      r_req[0][0] = 1'b1; r_idx[0][0] = 32'h40000002;
      for (int c = 0; c < 6; c++) begin
         dev_read_ack  = (c == 4);
         dev_read_data = (c == 4) ? 32'h12345678 : 32'h0;
         if (c == 5) r_req[0][0] = 1'b0;
         eval_cycle();
         cmp1("t1_dev_req", dev_read_req, (c >= 1 && c <= 4));
         cmp1("t1_a_ack", a_read_ack, (c == 4));
         cmp1("t1_b_ack", b_read_ack, 1'b0);
         if (c == 1) cmp("t1_idx", dev_read_index, 32'h40000002);
         if (c == 4) cmp("t1_data", a_read_data, 32'h12345678);
         advance();
      end
      quiet();

      // write tie: A first, then B, then the next tie goes to A again
      for (int c = 0; c < 9; c++) begin
         case (c)
            0: begin
               r_req[1][0] = 1'b1; r_idx[1][0] = 32'h100; r_dat[1][0] = 32'hA;
               r_req[1][1] = 1'b1; r_idx[1][1] = 32'h200; r_dat[1][1] = 32'hB;
            end
            3: r_req[1][0] = 1'b0;
            5: begin
               r_req[1][0] = 1'b1; r_idx[1][0] = 32'h101; r_dat[1][0] = 32'hA1;
               r_req[1][1] = 1'b1; r_idx[1][1] = 32'h201; r_dat[1][1] = 32'hB1;
            end
            7: begin r_req[1][0] = 1'b0; r_req[1][1] = 1'b0; end
            default: ;
         endcase
         dev_write_ack = (c == 2 || c == 4 || c == 6);
         eval_cycle();
         cmp1("t2_a_ack", a_write_ack, (c == 2 || c == 6));
         cmp1("t2_b_ack", b_write_ack, (c == 4));
         if (c == 1) cmp("t2_idx_a", dev_write_index, 32'h100);
         if (c == 1) cmp("t2_dat_a", dev_write_data, 32'hA);
         if (c == 4) cmp("t2_idx_b", dev_write_index, 32'h200);
         if (c == 6) cmp("t2_idx_a2", dev_write_index, 32'h101);
         advance();
      end
      quiet();

      // A reads while B writes
      for (int c = 0; c < 4; c++) begin
         if (c == 0) begin
            r_req[0][0] = 1'b1; r_idx[0][0] = 32'h11;
            r_req[1][1] = 1'b1; r_idx[1][1] = 32'h22; r_dat[1][1] = 32'h33;
         end
         if (c == 3) begin r_req[0][0] = 1'b0; r_req[1][1] = 1'b0; end
         dev_read_ack = (c == 2); dev_write_ack = (c == 2);
         dev_read_data = (c == 2) ? 32'h44 : 32'h0;
         eval_cycle();
         if (c == 1) begin
            cmp1("t3_rd_req", dev_read_req, 1'b1);
            cmp1("t3_wr_req", dev_write_req, 1'b1);
            cmp ("t3_rd_idx", dev_read_index, 32'h11);
            cmp ("t3_wr_dat", dev_write_data, 32'h33);
         end
         cmp1("t3_a_rack", a_read_ack, (c == 2));
         cmp1("t3_b_wack", b_write_ack, (c == 2));
         cmp1("t3_a_wack", a_write_ack, 1'b0);
         if (c == 2) cmp("t3_rdata", a_read_data, 32'h44);
         advance();
      end
      quiet();

      // B read never acked: timeout on the 8th BUSY cycle, then clear
      for (int c = 0; c < 12; c++) begin
         r_req[0][1] = (c <= 8); r_idx[0][1] = 32'h77;
         timeout_clear = (c == 10);
         eval_cycle();
         cmp1("t4_dev_req", dev_read_req, (c >= 1 && c <= 7));
         cmp1("t4_b_ack", b_read_ack, (c == 8));
         if (c == 8) cmp("t4_data", b_read_data, 32'hDEADBEEF);
         cmp1("t4_rd_to", read_timeout, (c == 9 || c == 10));
         cmp1("t4_wr_to", write_timeout, 1'b0);
         advance();
      end
      quiet();

      // ack arriving in the timeout cycle wins
      for (int c = 0; c < 10; c++) begin
         r_req[0][0] = (c <= 8); r_idx[0][0] = 32'h5;
         dev_read_ack = (c == 8); dev_read_data = (c == 8) ? 32'h55 : 32'h0;
         eval_cycle();
         cmp1("t5_a_ack", a_read_ack, (c == 8));
         if (c == 8) cmp("t5_data", a_read_data, 32'h55);
         if (c == 9) cmp1("t5_no_flag", read_timeout, 1'b0);
         advance();
      end
      quiet();

      // reset while a write is BUSY aborts it; the held request is then served
      for (int c = 0; c < 6; c++) begin
         r_req[1][0] = (c <= 4); r_idx[1][0] = 32'h99; r_dat[1][0] = 32'h98;
         reset = (c == 2);
         dev_write_ack = (c == 2 || c == 4);
         eval_cycle();
         cmp1("t6_a_ack", a_write_ack, (c == 4));
         cmp1("t6_dev_req", dev_write_req, (c == 1 || c == 4));
         if (c == 3) cmp("t6_idx_zero", dev_write_index, 32'h0);
         advance();
      end
      quiet();
      reset = 1'b0;

      for (int ph = 0; ph < 3; ph++) begin
         int pct;
         pct = (ph == 0) ? 30 : ((ph == 1) ? 0 : 80);
         for (int i = 0; i < 1000; i++) begin
            drive_random(pct);
            eval_cycle();
            advance();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
